// File: rtl/cordic_seq_if.sv
// rtl/cordic_seq_if.sv - handshake and datapath-control bundle for the CORDIC sequencer
interface cordic_seq_if;
   // operation request side
   logic       start;
   logic       mode_sel;
   logic       abort;
   logic       result_ack;
   // datapath feedback
   logic [3:0] counter;
   // datapath control and status
   logic       cordic_mode;
   logic [1:0] in_mux_ctl;
   logic       counter_rst;
   logic       counter_hold;
   logic       busy;
   logic       result_valid;
   logic       sync_err;

   // environment side: issues requests, owns the datapath counter
   modport master (
      output start, mode_sel, abort, result_ack, counter,
      input  cordic_mode, in_mux_ctl, counter_rst, counter_hold,
             busy, result_valid, sync_err
   );

   // sequencer side
   modport slave (
      input  start, mode_sel, abort, result_ack, counter,
      output cordic_mode, in_mux_ctl, counter_rst, counter_hold,
             busy, result_valid, sync_err
   );
endinterface

// File: rtl/cordic_seq.sv
// rtl/cordic_seq.sv - sequencing FSM for an iterative CORDIC datapath
module cordic_seq #(
   parameter int NUM_ITER = 8,
   parameter bit CHECK_EN = 1'b1
) (
   input logic        clka,
   input logic        reset,
   cordic_seq_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] ITER = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   // input mux encodings seen by the datapath
   localparam logic [1:0] MUX_THETA = 2'b00;
   localparam logic [1:0] MUX_XY    = 2'b10;
   localparam logic [1:0] MUX_FB    = 2'b01;
   localparam logic [1:0] MUX_HOLD  = 2'b11;

   // last micro-rotation index; iter_cnt stops here and never wraps
   localparam logic [3:0] LAST_ITER = 4'(NUM_ITER - 1);

   logic [1:0] state;
   logic [3:0] iter_cnt;
   logic       mode_q;
   logic       sync_err_q;
   logic       cnt_mismatch;

   // the datapath counter must track iter_cnt exactly while rotating
   assign cnt_mismatch = CHECK_EN && (bus.counter != iter_cnt);

   // state, iteration count, captured mode and sticky mismatch flag
   always_ff @(posedge clka) begin
      if (reset) begin
         state      <= IDLE;
         iter_cnt   <= 4'd0;
         mode_q     <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               iter_cnt <= 4'd0;
               if (bus.start) begin
                  state      <= LOAD;
                  mode_q     <= bus.mode_sel;
                  sync_err_q <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else begin
                  iter_cnt <= 4'd0;
                  state    <= ITER;
               end
            end
            ITER: begin
               // abort takes priority so a cancelled run never flags a mismatch
               if (bus.abort) begin
                  state <= IDLE;
               end else if (cnt_mismatch) begin
                  sync_err_q <= 1'b1;
                  state      <= IDLE;
               end else if (iter_cnt == LAST_ITER) begin
                  state <= DONE;
               end else begin
                  iter_cnt <= iter_cnt + 4'd1;
               end
            end
            DONE: begin
               // a start arriving with the ack is dropped; it must be re-issued in IDLE
               if (bus.abort || bus.result_ack) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // datapath controls decoded from state (and the registered mode only)
   always_comb begin
      bus.in_mux_ctl   = MUX_HOLD;
      bus.counter_rst  = 1'b1;
      bus.counter_hold = 1'b0;
      bus.result_valid = 1'b0;
      bus.busy         = 1'b1;
      case (state)
         IDLE: begin
            bus.busy = 1'b0;
         end
         LOAD: begin
            bus.in_mux_ctl = mode_q ? MUX_XY : MUX_THETA;
         end
         ITER: begin
            bus.in_mux_ctl  = MUX_FB;
            bus.counter_rst = 1'b0;
         end
         DONE: begin
            bus.counter_rst  = 1'b0;
            bus.counter_hold = 1'b1;
            bus.result_valid = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

   assign bus.cordic_mode = mode_q;
   assign bus.sync_err    = sync_err_q;

endmodule
